// File: rtl/wts_noise_pkg.sv
// Shared constants and LFSR next-state helper for the wave-table noise engine.
package wts_noise_pkg;

  localparam int FR_W   = 5;
  localparam int LFSR_W = 18;
  localparam int TAP_HI = 17;
  localparam int TAP_LO = 14;

  localparam logic [LFSR_W-1:0] LFSR_SEED = '1;

  // One shift of the Fibonacci LFSR. An all-zero register would stay stuck,
  // so it injects a 1 instead of the XOR feedback.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] state);
    logic fb;
    if (state == '0) begin
      fb = 1'b1;
    end else begin
      fb = state[TAP_HI] ^ state[TAP_LO];
    end
    return {state[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/wts_noise_step.sv
// Combinational next-state for one noise channel: divider down-count with
// reload from fr-1, LFSR shift on terminal count.
module wts_noise_step
  import wts_noise_pkg::*;
(
  input  logic [FR_W-1:0]   cnt,
  input  logic [FR_W-1:0]   fr,
  input  logic [LFSR_W-1:0] lfsr,
  output logic [FR_W-1:0]   cnt_next,
  output logic [LFSR_W-1:0] lfsr_next,
  output logic              tick
);

  assign tick      = (cnt == '0);
  assign cnt_next  = tick ? fr - FR_W'(1) : cnt - FR_W'(1);
  assign lfsr_next = tick ? wts_noise_pkg::lfsr_next(lfsr) : lfsr;

endmodule

// File: rtl/wts_noise_scheduler.sv
// Time-multiplexed noise engine: one shared step datapath serves one channel
// per active pulse in round-robin order. CPU writes wait in a single pending
// buffer and commit only in the target channel's own slot.
module wts_noise_scheduler
  import wts_noise_pkg::*;
#(
  parameter int CH_NUM = 5,
  parameter int SLOT_W = 3
) (
  input  logic              nreset,
  input  logic              clk,
  input  logic              active,
  input  logic [CH_NUM-1:0] enable,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [SLOT_W-1:0] wr_ch,
  input  logic [FR_W-1:0]   wr_fr,
  input  logic              wr_restart,
  output logic              wr_done,
  output logic [SLOT_W-1:0] slot,
  output logic [CH_NUM-1:0] noise
);

  logic [SLOT_W-1:0]             slot_q;
  logic [CH_NUM-1:0][FR_W-1:0]   cnt_q;
  logic [CH_NUM-1:0][FR_W-1:0]   fr_q;
  logic [CH_NUM-1:0][LFSR_W-1:0] lfsr_q;

  logic              pend_valid;
  logic [SLOT_W-1:0] pend_ch;
  logic [FR_W-1:0]   pend_fr;
  logic              pend_restart;
  logic              done_q;

  logic [FR_W-1:0]   cnt_sel;
  logic [FR_W-1:0]   fr_cur;
  logic [FR_W-1:0]   fr_sel;
  logic [LFSR_W-1:0] lfsr_sel;
  logic [FR_W-1:0]   cnt_nx;
  logic [LFSR_W-1:0] lfsr_nx;
  logic              tick;
  logic              commit_hit;
  logic              commit_drop;

  assign slot     = slot_q;
  assign wr_ready = ~pend_valid;
  assign wr_done  = done_q;

  // An out-of-range channel never matches a slot, so it is retired on any pulse.
  assign commit_hit  = active && pend_valid && (pend_ch == slot_q);
  assign commit_drop = active && pend_valid && (pend_ch > SLOT_W'(CH_NUM - 1));

  // Select the serviced channel's state into the shared step datapath.
  always_comb begin
    cnt_sel  = '0;
    fr_cur   = '0;
    lfsr_sel = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        cnt_sel  = cnt_q[i];
        fr_cur   = fr_q[i];
        lfsr_sel = lfsr_q[i];
      end
    end
  end

  // A committing write's frequency is used by a reload in that same step.
  assign fr_sel = commit_hit ? pend_fr : fr_cur;

  wts_noise_step u_step (
    .cnt       (cnt_sel),
    .fr        (fr_sel),
    .lfsr      (lfsr_sel),
    .cnt_next  (cnt_nx),
    .lfsr_next (lfsr_nx),
    .tick      (tick)
  );

  // Single-entry pending buffer: accept when empty, retire on commit or drop.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pend_valid   <= 1'b0;
      pend_ch      <= '0;
      pend_fr      <= '0;
      pend_restart <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wr_valid && !pend_valid) begin
        pend_valid   <= 1'b1;
        pend_ch      <= wr_ch;
        pend_fr      <= wr_fr;
        pend_restart <= wr_restart;
      end else if (commit_hit || commit_drop) begin
        pend_valid <= 1'b0;
        done_q     <= 1'b1;
      end
    end
  end

  // Round-robin slot pointer, advanced by each active pulse.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      slot_q <= '0;
    end else if (active) begin
      slot_q <= (slot_q == SLOT_W'(CH_NUM - 1)) ? '0 : slot_q + SLOT_W'(1);
    end
  end

  // Write back the step result (or a restart) into the serviced channel only.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < CH_NUM; i++) begin
        cnt_q[i]  <= '0;
        fr_q[i]   <= '0;
        lfsr_q[i] <= LFSR_SEED;
      end
    end else if (active) begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (slot_q == SLOT_W'(i)) begin
          if (commit_hit) begin
            fr_q[i] <= pend_fr;
          end
          if (commit_hit && pend_restart) begin
            cnt_q[i]  <= '0;
            lfsr_q[i] <= LFSR_SEED;
          end else begin
            cnt_q[i] <= cnt_nx;
            if (tick) begin
              lfsr_q[i] <= lfsr_nx;
            end
          end
        end
      end
    end
  end

  // Disabled channels output a steady 1.
  always_comb begin
    noise = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      noise[i] = ~enable[i] | lfsr_q[i][LFSR_W-1];
    end
  end

endmodule

// File: tb/tb_wts_noise_scheduler.sv
// Self-checking bench for wts_noise_scheduler against a behavioural model.
module tb_wts_noise_scheduler;

  localparam int CH = 5;
  localparam logic [17:0] SEED = 18'h3FFFF;

  logic        nreset;
  logic        clk;
  logic        active;
  logic [4:0]  enable;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_ch;
  logic [4:0]  wr_fr;
  logic        wr_restart;
  logic        wr_done;
  logic [2:0]  slot;
  logic [4:0]  noise;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  int          m_slot;
  logic [4:0]  m_cnt  [CH];
  logic [4:0]  m_fr   [CH];
  logic [17:0] m_lfsr [CH];
  bit          m_pend;
  int          m_pch;
  logic [4:0]  m_pfr;
  bit          m_prs;
  bit          m_done;

  wts_noise_scheduler dut (
    .nreset     (nreset),
    .clk        (clk),
    .active     (active),
    .enable     (enable),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_ch      (wr_ch),
    .wr_fr      (wr_fr),
    .wr_restart (wr_restart),
    .wr_done    (wr_done),
    .slot       (slot),
    .noise      (noise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] exp_noise();
    logic [4:0] r;
    for (int i = 0; i < CH; i++) r[i] = ~enable[i] | m_lfsr[i][17];
    return r;
  endfunction

  task automatic model_reset();
    m_slot = 0;
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0; m_fr[i] = 0; m_lfsr[i] = SEED;
    end
    m_pend = 0; m_pch = 0; m_pfr = 0; m_prs = 0; m_done = 0;
  endtask

  // Divider: period is fr steps (fr=0 means 32); lfsr advances on the wrap step.
  task automatic model_step(input int s);
    if (m_cnt[s] == 0) begin
      m_cnt[s] = m_fr[s] - 5'd1;
      if (m_lfsr[s] == 0) m_lfsr[s] = 18'h1;
      else m_lfsr[s] = {m_lfsr[s][16:0], m_lfsr[s][17] ^ m_lfsr[s][14]};
    end else begin
      m_cnt[s] = m_cnt[s] - 5'd1;
    end
  endtask

  task automatic model_edge(input bit act, input bit v, input int ch,
                            input logic [4:0] fr, input bit rs);
    bit commit;
    commit = m_pend && act && (m_pch == m_slot || m_pch >= CH);
    m_done = commit;
    if (act) begin
      if (commit && m_pch == m_slot) begin
        m_fr[m_slot] = m_pfr;
        if (m_prs) begin
          m_cnt[m_slot] = 0;
          m_lfsr[m_slot] = SEED;
        end else begin
          model_step(m_slot);
        end
      end else begin
        model_step(m_slot);
      end
      m_slot = (m_slot + 1) % CH;
    end
    if (m_pend) begin
      if (commit) m_pend = 0;
    end else if (v) begin
      m_pend = 1; m_pch = ch; m_pfr = fr; m_prs = rs;
    end
  endtask

  task automatic clk_step(input bit act, input bit v, input logic [2:0] ch,
                          input logic [4:0] fr, input bit rs);
    @(negedge clk);
    active = act; wr_valid = v; wr_ch = ch; wr_fr = fr; wr_restart = rs;
    @(posedge clk);
    model_edge(act, v, int'(ch), fr, rs);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0; active = 0; wr_valid = 0; wr_ch = 0; wr_fr = 0; wr_restart = 0;
    model_reset();
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    enable = 5'b00000;
    do_reset();
    #1;
    n_checks++; if (slot !== 3'd0) begin n_fail++; $display("FAIL reset_slot got=%0d exp=0", slot); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    n_checks++; if (wr_done !== 1'b0) begin n_fail++; $display("FAIL reset_wr_done got=%b exp=0", wr_done); end
    n_checks++; if (noise !== 5'b11111) begin n_fail++; $display("FAIL reset_noise got=%b exp=11111", noise); end
    for (int i = 0; i < CH; i++) begin
      n_checks++;
      if (dut.cnt_q[i] !== 5'd0 || dut.fr_q[i] !== 5'd0 || dut.lfsr_q[i] !== SEED) begin
        n_fail++;
        $display("FAIL reset_state ch%0d got cnt=%0d fr=%0d lfsr=%h", i, dut.cnt_q[i], dut.fr_q[i], dut.lfsr_q[i]);
      end
    end
  endtask

  task automatic test_free_run();
    enable = 5'b00000;
    do_reset();
    for (int p = 0; p < 10; p++) begin
      n_checks++; if (slot !== 3'(p % CH)) begin n_fail++; $display("FAIL free_slot p=%0d got=%0d exp=%0d", p, slot, p % CH); end
      clk_step(1, 0, 0, 0, 0);
      n_checks++; if (noise !== 5'b11111) begin n_fail++; $display("FAIL free_noise p=%0d got=%b exp=11111", p, noise); end
      if (p == CH - 1) begin
        for (int i = 0; i < CH; i++) begin
          n_checks++;
          if (dut.cnt_q[i] !== 5'd31 || dut.lfsr_q[i] !== 18'h3FFFE) begin
            n_fail++;
            $display("FAIL free_first_step ch%0d got cnt=%0d lfsr=%h exp cnt=31 lfsr=3fffe", i, dut.cnt_q[i], dut.lfsr_q[i]);
          end
        end
      end
    end
  endtask

  task automatic test_commit_ch2();
    enable = 5'b00100;
    do_reset();
    clk_step(0, 1, 3'd2, 5'd3, 0);
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL c2_ready_drop got=%b exp=0", wr_ready); end
    for (int p = 0; p < 3; p++) begin
      clk_step(1, 0, 0, 0, 0);
      if (p < 2) begin
        n_checks++; if (wr_done !== 1'b0 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL c2_early_commit p=%0d done=%b ready=%b exp 0 0", p, wr_done, wr_ready); end
      end
    end
    n_checks++; if (wr_done !== 1'b1 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL c2_commit done=%b ready=%b exp 1 1", wr_done, wr_ready); end
    n_checks++; if (dut.fr_q[2] !== 5'd3 || dut.cnt_q[2] !== 5'd2) begin n_fail++; $display("FAIL c2_new_fr fr=%0d cnt=%0d exp fr=3 cnt=2", dut.fr_q[2], dut.cnt_q[2]); end
    clk_step(0, 0, 0, 0, 0);
    n_checks++; if (wr_done !== 1'b0) begin n_fail++; $display("FAIL c2_done_pulse got=%b exp=0", wr_done); end
    for (int p = 0; p < 60; p++) begin
      clk_step(1, 0, 0, 0, 0);
      n_checks++;
      if (dut.lfsr_q[2] !== m_lfsr[2] || noise !== exp_noise()) begin
        n_fail++;
        $display("FAIL c2_run p=%0d lfsr=%h exp=%h noise=%b exp=%b", p, dut.lfsr_q[2], m_lfsr[2], noise, exp_noise());
      end
    end
  endtask

  task automatic test_restart_ch4();
    logic [17:0] prev;
    enable = 5'b10000;
    do_reset();
    for (int p = 0; p < CH; p++) clk_step(1, 0, 0, 0, 0);
    clk_step(0, 1, 3'd4, 5'd1, 1);
    for (int p = 0; p < CH; p++) clk_step(1, 0, 0, 0, 0);
    n_checks++; if (wr_done !== 1'b1) begin n_fail++; $display("FAIL rs4_done got=%b exp=1", wr_done); end
    n_checks++;
    if (dut.cnt_q[4] !== 5'd0 || dut.lfsr_q[4] !== SEED || dut.fr_q[4] !== 5'd1) begin
      n_fail++;
      $display("FAIL rs4_commit cnt=%0d lfsr=%h fr=%0d exp cnt=0 lfsr=3ffff fr=1", dut.cnt_q[4], dut.lfsr_q[4], dut.fr_q[4]);
    end
    prev = SEED;
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < CH; p++) clk_step(1, 0, 0, 0, 0);
      n_checks++;
      if (dut.cnt_q[4] !== 5'd0 || dut.lfsr_q[4] !== m_lfsr[4] || dut.lfsr_q[4] === prev) begin
        n_fail++;
        $display("FAIL rs4_shift k=%0d cnt=%0d lfsr=%h exp cnt=0 lfsr=%h", k, dut.cnt_q[4], dut.lfsr_q[4], m_lfsr[4]);
      end
      prev = m_lfsr[4];
    end
    n_checks++; if (noise !== exp_noise()) begin n_fail++; $display("FAIL rs4_noise got=%b exp=%b", noise, exp_noise()); end
  endtask

  task automatic test_out_of_range();
    enable = 5'b11111;
    do_reset();
    for (int p = 0; p < 3; p++) clk_step(1, 0, 0, 0, 0);
    clk_step(0, 1, 3'd6, 5'd7, 1);
    clk_step(1, 0, 0, 0, 0);
    n_checks++; if (wr_done !== 1'b1 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL oor_drop done=%b ready=%b exp 1 1", wr_done, wr_ready); end
    for (int i = 0; i < CH; i++) begin
      n_checks++;
      if (dut.fr_q[i] !== 5'd0 || dut.cnt_q[i] !== m_cnt[i] || dut.lfsr_q[i] !== m_lfsr[i]) begin
        n_fail++;
        $display("FAIL oor_state ch%0d fr=%0d cnt=%0d lfsr=%h exp fr=0 cnt=%0d lfsr=%h", i, dut.fr_q[i], dut.cnt_q[i], dut.lfsr_q[i], m_cnt[i], m_lfsr[i]);
      end
    end
  endtask

  task automatic test_zero_escape();
    enable = 5'b00010;
    do_reset();
    @(negedge clk);
    dut.lfsr_q[1] <= '0;
    m_lfsr[1] = '0;
    clk_step(1, 0, 0, 0, 0);
    clk_step(1, 0, 0, 0, 0);
    n_checks++; if (dut.lfsr_q[1] !== 18'h00001) begin n_fail++; $display("FAIL zero_escape got=%h exp=00001", dut.lfsr_q[1]); end
    n_checks++; if (noise !== 5'b11101) begin n_fail++; $display("FAIL zero_noise got=%b exp=11101", noise); end
  endtask

  task automatic test_back_to_back();
    bit prev_done;
    int dones;
    enable = 5'b01010;
    do_reset();
    prev_done = 0;
    dones = 0;
    for (int c = 0; c < 80; c++) begin
      clk_step(c % 2 == 1, 1, (c / 16) % 2 == 0 ? 3'd1 : 3'd3, 5'(c), 0);
      n_checks++;
      if (wr_ready !== !m_pend || wr_done !== m_done) begin
        n_fail++;
        $display("FAIL b2b_port c=%0d ready=%b exp=%b done=%b exp=%b", c, wr_ready, !m_pend, wr_done, m_done);
      end
      if (prev_done) begin
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_reaccept c=%0d ready=%b exp=0", c, wr_ready); end
      end
      if (wr_done === 1'b1) dones++;
      prev_done = (wr_done === 1'b1);
    end
    for (int i = 0; i < CH; i++) begin
      n_checks++;
      if (dut.fr_q[i] !== m_fr[i] || dut.cnt_q[i] !== m_cnt[i]) begin
        n_fail++;
        $display("FAIL b2b_state ch%0d fr=%0d exp=%0d cnt=%0d exp=%0d", i, dut.fr_q[i], m_fr[i], dut.cnt_q[i], m_cnt[i]);
      end
    end
    n_checks++; if (dones < 4) begin n_fail++; $display("FAIL b2b_commits got=%0d exp>=4", dones); end
  endtask

  task automatic test_reset_midwrite();
    enable = 5'b11111;
    do_reset();
    for (int p = 0; p < 7; p++) clk_step(1, 0, 0, 0, 0);
    clk_step(0, 1, 3'd3, 5'd9, 1);
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL rmw_pending ready=%b exp=0", wr_ready); end
    @(negedge clk);
    active = 0; wr_valid = 0;
    #2 nreset = 1'b0;
    #1;
    model_reset();
    n_checks++; if (slot !== 3'd0 || wr_ready !== 1'b1 || wr_done !== 1'b0) begin n_fail++; $display("FAIL rmw_async slot=%0d ready=%b done=%b exp 0 1 0", slot, wr_ready, wr_done); end
    for (int i = 0; i < CH; i++) begin
      n_checks++;
      if (dut.cnt_q[i] !== 5'd0 || dut.fr_q[i] !== 5'd0 || dut.lfsr_q[i] !== SEED) begin
        n_fail++;
        $display("FAIL rmw_state ch%0d cnt=%0d fr=%0d lfsr=%h", i, dut.cnt_q[i], dut.fr_q[i], dut.lfsr_q[i]);
      end
    end
    @(negedge clk);
    nreset = 1'b1;
    for (int p = 0; p < 12; p++) begin
      clk_step(1, 0, 0, 0, 0);
      n_checks++; if (wr_done !== 1'b0 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL rmw_ghost p=%0d done=%b ready=%b exp 0 1", p, wr_done, wr_ready); end
    end
    n_checks++; if (dut.fr_q[3] !== 5'd0) begin n_fail++; $display("FAIL rmw_fr3 got=%0d exp=0", dut.fr_q[3]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      enable = 5'($urandom);
      clk_step($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, 3'($urandom),
               5'($urandom_range(0, 6)), $urandom_range(0, 3) == 0);
      n_checks++;
      if (slot !== 3'(m_slot) || wr_ready !== !m_pend || wr_done !== m_done || noise !== exp_noise()) begin
        n_fail++;
        $display("FAIL rnd_outputs c=%0d slot=%0d/%0d ready=%b/%b done=%b/%b noise=%b/%b", c, slot, m_slot, wr_ready, !m_pend, wr_done, m_done, noise, exp_noise());
      end
      for (int i = 0; i < CH; i++) begin
        n_checks++;
        if (dut.cnt_q[i] !== m_cnt[i] || dut.fr_q[i] !== m_fr[i] || dut.lfsr_q[i] !== m_lfsr[i]) begin
          n_fail++;
          $display("FAIL rnd_state c=%0d ch%0d cnt=%0d/%0d fr=%0d/%0d lfsr=%h/%h", c, i, dut.cnt_q[i], m_cnt[i], dut.fr_q[i], m_fr[i], dut.lfsr_q[i], m_lfsr[i]);
        end
      end
    end
  endtask

  initial begin
    nreset = 1'b0; active = 0; enable = 0; wr_valid = 0; wr_ch = 0; wr_fr = 0; wr_restart = 0;
    model_reset();
    test_reset();
    test_free_run();
    test_commit_ch2();
    test_restart_ch4();
    test_out_of_range();
    test_zero_escape();
    test_back_to_back();
    test_reset_midwrite();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
